// File: rtl/sar_code_decoder.sv
// sar_code_decoder: decodes a 4-bit code into y = 1000 - 30*x, one code bit per cycle, MSB first.
// Define ABS_ERROR_EN to add the registered |y - target| output on err.
module sar_code_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] x,
  input  logic [9:0] target,
  output logic       busy,
  output logic       done,
  output logic [9:0] y
`ifdef ABS_ERROR_EN
  ,
  output logic [9:0] err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [3:0] x_lat_r;
  logic [9:0] acc_r;
  logic [1:0] idx_r;
  logic       busy_r;
  logic       done_r;
  logic [9:0] y_r;
  logic [9:0] sub_s;
  logic [9:0] acc_nxt_s;
  logic       last_bit_s;
  logic       accept_s;

  // Next-state decode; start only matters in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (idx_r == 2'd0) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Weight of the current bit and the accumulator value after removing it
  always_comb begin
    sub_s      = 10'd0;
    accept_s   = (state_r == IDLE) && start;
    last_bit_s = (state_r == CALC) && (idx_r == 2'd0);
    if (x_lat_r[idx_r]) begin
      sub_s = 10'd30 << idx_r;
    end else begin
      sub_s = 10'd0;
    end
    acc_nxt_s = acc_r - sub_s;
  end

  // Control and datapath registers; y is only written on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      x_lat_r <= 4'd0;
      acc_r   <= 10'd0;
      idx_r   <= 2'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      y_r     <= 10'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= last_bit_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_lat_r <= x;
            acc_r   <= 10'd1000;
            idx_r   <= 2'd3;
          end else begin
            x_lat_r <= x_lat_r;
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          idx_r <= idx_r - 2'd1;
          if (last_bit_s) begin
            y_r <= acc_nxt_s;
          end else begin
            y_r <= y_r;
          end
        end
        DONE:    acc_r <= acc_r;
        default: acc_r <= acc_r;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign y    = y_r;

`ifdef ABS_ERROR_EN
  logic [9:0] target_lat_r;
  logic [9:0] err_r;
  logic [9:0] abs_s;

  // Distance between final accumulator and target, ordered to avoid wraparound
  always_comb begin
    abs_s = 10'd0;
    if (acc_nxt_s >= target_lat_r) begin
      abs_s = acc_nxt_s - target_lat_r;
    end else begin
      abs_s = target_lat_r - acc_nxt_s;
    end
  end

  // Target latch and registered error, updated with y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_lat_r <= 10'd0;
      err_r        <= 10'd0;
    end else begin
      if (accept_s) begin
        target_lat_r <= target;
      end else begin
        target_lat_r <= target_lat_r;
      end
      if (last_bit_s) begin
        err_r <= abs_s;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`else
  logic unused_target_s;
  assign unused_target_s = ^target;
`endif

endmodule

// File: tb/tb_sar_code_decoder.sv
// Self-checking bench for sar_code_decoder: latency-based reference model compared every cycle,
// plus literal checks for known codes, held start, mid-conversion reset and back-to-back runs.
module tb_sar_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] x = 4'd0;
  logic [9:0] target = 10'd0;
  logic       busy;
  logic       done;
  logic [9:0] y;
`ifdef ABS_ERROR_EN
  logic [9:0] err;
`endif

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sar_code_decoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .target (target),
    .busy   (busy),
    .done   (done),
    .y      (y)
`ifdef ABS_ERROR_EN
    ,
    .err    (err)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int decode(input int xv);
    return 1000 - 30 * xv;
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Reference model: a conversion accepted at edge N reports at N+4 and is idle again at N+5
  int phase = 0;
  int pend_y = 0;
  int pend_err = 0;
  int exp_y = 0;
  int exp_err = 0;
  bit exp_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 0;
      exp_y    <= 0;
      exp_err  <= 0;
      exp_done <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase    <= 1;
        pend_y   <= decode(int'(x));
        pend_err <= absdiff(decode(int'(x)), int'(target));
      end
    end else if (phase <= 3) begin
      phase <= phase + 1;
    end else if (phase == 4) begin
      phase    <= 5;
      exp_y    <= pend_y;
      exp_err  <= pend_err;
      exp_done <= 1'b1;
    end else begin
      phase    <= 0;
      exp_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("done", 32'(done), 32'(exp_done));
      chk("y", 32'(y), 32'(exp_y));
`ifdef ABS_ERROR_EN
      chk("err", 32'(err), 32'(exp_err));
`endif
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic conv_lit(input int xv, input int tv, input int ey, input int ee);
    int cnt;
    bit got;
    @(posedge clk);
    #1;
    start  = 1'b1;
    x      = 4'(xv);
    target = 10'(tv);
    @(posedge clk);
    #1;
    start  = 1'b0;
    x      = 4'($urandom);
    target = 10'($urandom);
    cnt = 0;
    got = 1'b0;
    while (cnt < 10 && !got) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) got = 1'b1;
    end
    chk("latency", 32'(cnt), 32'd4);
    chk("lit_y", 32'(y), 32'(ey));
`ifdef ABS_ERROR_EN
    chk("lit_err", 32'(err), 32'(ee));
`else
    if (ee < 0) $display("note: negative err expectation %0d", ee);
`endif
  endtask

  initial begin
    int pulses;
    int prev;
    int hy;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    rst_n = 1'b1;

    conv_lit(12, 630, 640, 10);
    conv_lit(7, 780, 790, 10);
    conv_lit(0, 1000, 1000, 0);
    conv_lit(15, 600, 550, 50);

    // start held two cycles, x changes in the second
    @(posedge clk);
    #1;
    start = 1'b1;
    x = 4'd9;
    @(posedge clk);
    #1;
    x = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    hy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        hy = int'(y);
      end
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    chk("hold_y", 32'(hy), 32'd730);

    // reset during the conversion aborts it
    @(posedge clk);
    #1;
    start = 1'b1;
    x = 4'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    conv_lit(5, 900, 850, 50);

    // continuous start: back-to-back conversions every 6 cycles
    @(posedge clk);
    #1;
    start = 1'b1;
    x = 4'd1;
    pulses = 0;
    prev = -1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        chk("b2b_y", 32'(y), 32'd970);
        if (prev >= 0) chk("b2b_spacing", 32'(cyc - prev), 32'd6);
        prev = cyc;
        pulses++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(pulses >= 3), 32'd1);
    wait_idle();

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      start  = 1'($urandom_range(0, 1));
      x      = 4'($urandom);
      target = 10'($urandom);
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sar_code_decoder.md
SAR_CODE_DECODER -- requirements
Module: sar_code_decoder

Interface
REQ-001: The block SHALL use one clock and an asynchronous active-low reset; all state SHALL be registered on the rising clock edge.
REQ-002: clk  input  1  system clock.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: start  input  1  level request, sampled only in IDLE.
REQ-005: x  input  4  code to decode, latched on accepted start.
REQ-006: target  input  10  reference value, latched on accepted start; used only with ABS_ERROR_EN.
REQ-007: busy  output  1  high while state is not IDLE.
REQ-008: done  output  1  one-cycle completion pulse.
REQ-009: y  output  10  decoded value, y = 1000 - 30*x, held until the next completion.
REQ-010: err  output  10  |y - target|; present only with ABS_ERROR_EN.

Function
REQ-011: The FSM SHALL have the states IDLE, CALC and DONE.
REQ-012: IDLE -> CALC SHALL occur on the edge where start=1; that edge latches x, latches target, loads acc=1000 and sets bit index=3.
REQ-013: CALC SHALL process one code bit per cycle, MSB first; each cycle does acc -= (30 << i) when x_lat[i]=1 and decrements i.
REQ-014: CALC -> DONE SHALL occur on the edge that processes bit 0; that same edge loads y with the final acc and asserts done.
REQ-015: DONE -> IDLE SHALL occur unconditionally on the next edge, clearing done.
REQ-016: Latency SHALL be fixed: start sampled at edge N gives y valid and done=1 from edge N+4 to N+5, busy=1 from N to N+5, and IDLE again at N+5.
REQ-017: start SHALL be ignored in CALC and DONE; holding start high across completion SHALL begin a new conversion at the first IDLE sampling edge (N+6).
REQ-018: Changes on x or target after the accepting edge SHALL NOT affect the result in progress.
REQ-019: acc SHALL be 10-bit unsigned; the valid range is 550..1000 and no underflow is possible; no saturation logic is required.
REQ-020: The output y SHALL change only on the completion edge; it SHALL NOT expose intermediate acc values.

Reset
REQ-021: Asserting rst_n low SHALL immediately force: state=IDLE, busy=0, done=0, y=0, err=0, acc=0, latched x/target=0.
REQ-022: Reset asserted mid-CALC SHALL abort the conversion with no done pulse; after release, the block SHALL accept start normally.
REQ-023: The first start sampled after rst_n deasserts SHALL be honoured.

Configuration
REQ-024: The macro ABS_ERROR_EN SHALL control the err path.
REQ-025: With ABS_ERROR_EN defined, err SHALL be registered on the completion edge as |final acc - target_lat|, computed without wraparound, and held with y.
REQ-026: Without ABS_ERROR_EN, the err port, the target latch and the subtract/compare logic SHALL be absent, and all other timing SHALL be unchanged.

Verification
REQ-027: x=12, target=630, start pulse -> done 4 cycles after the accepting edge, y=640, err=10.
REQ-028: x=7, target=780 -> y=790, err=10; x=0 -> y=1000; x=15 -> y=550 (range endpoints).
REQ-029: start held high for 2 cycles, with x changed to 3 in cycle 2 -> exactly one conversion of the original x, a single done pulse, and no restart during CALC.
REQ-030: rst_n pulsed low during the second CALC cycle -> outputs zero immediately, no done; a later start with x=5 -> y=850.
REQ-031: start held continuously high with x=1 -> back-to-back conversions, done pulses 6 cycles apart, each with y=970.
REQ-032: Build without ABS_ERROR_EN -> REQ-027/028 give identical y and done timing, and no err port exists.
